vexp_vec: RTL and testbench

Multi-lane bf16 exponential unit for the vector datapath. It computes e^x or 2^x on LANES bf16 elements at once, using a fixed-point range reduction and a cubic Horner polynomial. The block is self-contained: it has no external multiplier or adder. It sits behind the vector issue stage with a valid/ready handshake on both sides.

---
 rtl/vexp_vec.sv | 198 +++++++++++++++++++
 tb/tb_vexp_vec.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vexp_vec.sv
// Multi-lane bf16 e^x / 2^x unit: fixed-point range reduction plus cubic Horner polynomial.
// Optional per-lane enable mask is compiled in with VEXP_LANE_MASK_EN.
module vexp_vec #(
  parameter int LANES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [16*LANES-1:0]  a,
`ifdef VEXP_LANE_MASK_EN
  input  logic [LANES-1:0]     mask,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*LANES-1:0]  result,
  output logic                 busy
);

  // state | meaning
  // IDLE  | waiting for an input vector
  // LOAD  | special-case detect, operand to Q8.16
  // SCALE | multiply by log2(e) for e^x, split into n / f
  // H3    | first Horner step
  // H2    | second Horner step
  // H1    | last Horner step, p in Q1.16
  // PACK  | round, assemble bf16, register result
  // OUT   | result valid, waiting for out_ready
  typedef enum logic [2:0] {IDLE, LOAD, SCALE, H3, H2, H1, PACK, OUT} state_t;

  typedef struct packed {
    logic               sp;
    logic [15:0]        spv;
    logic signed [24:0] xq;
  } load_t;

  state_t state, state_nxt;
  logic   accept;

  logic [16*LANES-1:0] a_r;
  logic                op_r;
  logic [LANES-1:0]    en_r;

  logic               sp_r  [LANES];
  logic [15:0]        spv_r [LANES];
  logic signed [24:0] xq_r  [LANES];
  logic signed [25:0] t_r   [LANES];
  logic [17:0]        acc_r [LANES];

  load_t               ld      [LANES];
  logic signed [25:0]  t_nxt   [LANES];
  logic [17:0]         acc_nxt [LANES];
  logic [17:0]         base;
  logic [16*LANES-1:0] res_all;

  function automatic load_t load_lane(input logic [15:0] x);
    load_t       r;
    logic [7:0]  e;
    logic [24:0] mag;
    r   = '0;
    e   = x[14:7];
    mag = {17'd0, 1'b1, x[6:0]} << (e - 8'd118);
    if (e == 8'hFF) begin
      r.sp  = 1'b1;
      r.spv = (x[6:0] != 7'd0) ? 16'h7FC0 : (x[15] ? 16'h0000 : 16'h7F80);
    end else if (e >= 8'd134) begin
      r.sp  = 1'b1;
      r.spv = x[15] ? 16'h0000 : 16'h7F80;
    end else if (e < 8'd118) begin
      r.sp  = 1'b1;
      r.spv = 16'h3F80;
    end else begin
      r.xq = x[15] ? -$signed(mag) : $signed(mag);
    end
    return r;
  endfunction

  function automatic logic signed [25:0] scale_lane(input logic signed [24:0] xq, input logic o);
    logic signed [43:0] prod;
    prod = $signed({{19{xq[24]}}, xq}) * 44'sd94548;
    return o ? {xq[24], xq} : 26'(prod >>> 16);
  endfunction

  function automatic logic [17:0] horner(input logic [15:0] f, input logic [16:0] k,
                                         input logic [17:0] b);
    logic [32:0] prod;
    prod = {17'd0, f} * {16'd0, k};
    return b + 18'(prod >> 16);
  endfunction

  // p[16] is the implicit leading one of Q1.16; only a carry above it bumps the exponent.
  function automatic logic [15:0] pack_lane(input logic ptop, input logic [7:0] pm,
                                            input logic [9:0] n);
    logic [7:0]         m;
    logic               ovf;
    logic signed [11:0] e;
    m   = {1'b0, pm[7:1]} + {7'd0, pm[0]};
    ovf = m[7] | ptop;
    e   = $signed({{2{n[9]}}, n} + 12'd127 + {11'd0, ovf});
    if (e > 12'sd254)    return 16'h7F80;
    else if (e < 12'sd1) return 16'h0000;
    else                 return {1'b0, e[7:0], ovf ? 7'd0 : m[6:0]};
  endfunction

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD:  state_nxt = SCALE;
      SCALE: state_nxt = H3;
      H3:    state_nxt = H2;
      H2:    state_nxt = H1;
      H1:    state_nxt = PACK;
      PACK:  state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      H3:      base = 18'h039A0;
      H2:      base = 18'h0B220;
      default: base = 18'h10000;
    endcase
  end

  always_comb begin
    res_all = '0;
    for (int i = 0; i < LANES; i++) begin
      ld[i]      = load_lane(a_r[16*i +: 16]);
      t_nxt[i]   = scale_lane(xq_r[i], op_r);
      acc_nxt[i] = horner(t_r[i][15:0], (state == H3) ? 17'h01440 : acc_r[i][16:0], base);
      if (!en_r[i])      res_all[16*i +: 16] = a_r[16*i +: 16];
      else if (sp_r[i])  res_all[16*i +: 16] = spv_r[i];
      else               res_all[16*i +: 16] = pack_lane(acc_r[i][17], acc_r[i][15:8],
                                                         t_r[i][25:16]);
    end
  end

`ifdef VEXP_LANE_MASK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         en_r <= '0;
    else if (accept) en_r <= mask;
  end
`else
  assign en_r = '1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_r    <= '0;
      op_r   <= 1'b0;
      result <= '0;
      for (int i = 0; i < LANES; i++) begin
        sp_r[i]  <= 1'b0;
        spv_r[i] <= '0;
        xq_r[i]  <= '0;
        t_r[i]   <= '0;
        acc_r[i] <= '0;
      end
    end else begin
      if (accept) begin
        a_r  <= a;
        op_r <= op;
      end
      for (int i = 0; i < LANES; i++) begin
        if (state == LOAD) begin
          sp_r[i]  <= ld[i].sp;
          spv_r[i] <= ld[i].spv;
          xq_r[i]  <= ld[i].xq;
        end
        if (state == SCALE) t_r[i] <= t_nxt[i];
        if (state == H3 || state == H2 || state == H1) acc_r[i] <= acc_nxt[i];
      end
      if (state == PACK) result <= res_all;
    end
  end

endmodule

// File: tb/tb_vexp_vec.sv
// Directed and randomized bench for vexp_vec against an arithmetic reference model.
// Define VEXP_LANE_MASK_EN for both bench and RTL to exercise the lane mask.
module tb_vexp_vec;
  localparam int LANES = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op = 1'b0;
  logic [63:0] a = '0;
  logic [3:0]  mask = 4'hF;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  vexp_vec #(.LANES(LANES)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
`ifdef VEXP_LANE_MASK_EN
    .mask      (mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: spec arithmetic on plain integers (floor shifts, truncated products).
  function automatic logic [15:0] model(input logic o, input logic [15:0] x);
    int e;
    longint sig, xq, t, n, f, acc, p, mant, ex;
    e   = int'(x[14:7]);
    sig = 128 + longint'(x[6:0]);
    if (e == 255) return (x[6:0] != 7'd0) ? 16'h7FC0 : (x[15] ? 16'h0000 : 16'h7F80);
    if (e >= 134) return x[15] ? 16'h0000 : 16'h7F80;
    if (e < 118)  return 16'h3F80;
    xq = sig << (e - 118);
    if (x[15]) xq = -xq;
    t    = o ? xq : ((xq * 94548) >>> 16);
    n    = t >>> 16;
    f    = t & 65535;
    acc  = 14752 + ((f * 5184) >>> 16);
    acc  = 45600 + ((f * acc) >>> 16);
    p    = 65536 + ((f * acc) >>> 16);
    mant = ((p >>> 9) & 127) + ((p >>> 8) & 1);
    if (mant > 127 || p >= 131072) begin
      mant = 0;
      n    = n + 1;
    end
    ex = n + 127;
    if (ex > 254) return 16'h7F80;
    if (ex < 1)   return 16'h0000;
    return {1'b0, ex[7:0], mant[6:0]};
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [7:0] e;
    case ($urandom_range(0, 11))
      0:       e = 8'hFF;
      1:       e = 8'd140;
      2:       e = 8'd0;
      3:       e = 8'd110;
      default: e = 8'($urandom_range(116, 135));
    endcase
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge CLK); @(negedge CLK);
      lat++;
      if (!out_valid) chk({tag, "_no_overlap"}, {63'd0, in_ready}, 64'd0);
    end while (!out_valid && lat < 20);
    chk({tag, "_latency"}, 64'(lat), 64'd6);
  endtask

  task automatic run_vec(input string tag, input logic o, input logic [63:0] x,
                         input logic [3:0] m, input logic [63:0] exp);
    @(negedge CLK);
    in_valid = 1'b1; op = o; a = x; mask = m;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge CLK); @(negedge CLK);
    in_valid = 1'b0; op = ~o; a = ~x; mask = ~m;
    chk({tag, "_busy"}, {62'd0, busy, in_ready}, 64'd2);
    wait_out(tag);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_ready_low"}, {63'd0, in_ready}, 64'd0);
    @(posedge CLK); @(negedge CLK);
    chk({tag, "_idle"}, {61'd0, out_valid, in_ready, busy}, 64'd2);
  endtask

  initial begin
    logic [63:0] x, exp;
    logic [3:0]  m;
    logic        o;

    repeat (3) @(negedge CLK);
    chk("rst_hold", {result, 61'd0, in_ready, out_valid, busy} , {64'd0, 61'd0, 3'b100});
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_release", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("rst_result", result, 64'd0);

    run_vec("exp_one", 1'b0, {4{16'h3F80}}, 4'hF, {4{16'h402E}});
    run_vec("pow2_mix", 1'b1, {16'h8000, 16'h0000, 16'hBF80, 16'h4040}, 4'hF,
            {16'h3F80, 16'h3F80, 16'h3F00, 16'h4100});
    run_vec("exp_special", 1'b0, {16'hFF80, 16'h7FC1, 16'hC2C8, 16'h42C8}, 4'hF,
            {16'h0000, 16'h7FC0, 16'h0000, 16'h7F80});

    // Backpressure: OUT held while out_ready=0, a second request is ignored.
    @(negedge CLK);
    out_ready = 1'b0; in_valid = 1'b1; op = 1'b0; a = {4{16'h3F80}};
    @(posedge CLK); @(negedge CLK);
    in_valid = 1'b0;
    wait_out("bp");
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; op = 1'b1; a = {4{16'h4040}};
      chk("bp_hold_result", result, {4{16'h402E}});
      chk("bp_hold_flags", {62'd0, out_valid, in_ready}, 64'd2);
      @(posedge CLK); @(negedge CLK);
    end
    chk("bp_hold_last", result, {4{16'h402E}});
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("bp_release", {61'd0, out_valid, in_ready, busy}, 64'd2);
    @(posedge CLK); @(negedge CLK);
    chk("bp_no_queue", {61'd0, out_valid, in_ready, busy}, 64'd2);

    // Reset while in H2 aborts the vector.
    @(negedge CLK);
    in_valid = 1'b1; op = 1'b1; a = {4{16'h4040}};
    @(posedge CLK); @(negedge CLK);
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort_flags", {61'd0, out_valid, busy, in_ready}, 64'd1);
    chk("abort_result", result, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_idle", {61'd0, out_valid, busy, in_ready}, 64'd1);
    run_vec("after_abort", 1'b1, {4{16'h4040}}, 4'hF, {4{16'h4100}});

`ifdef VEXP_LANE_MASK_EN
    run_vec("mask_0101", 1'b1, {4{16'h4040}}, 4'b0101,
            {16'h4040, 16'h4100, 16'h4040, 16'h4100});
`endif

    for (int v = 0; v < 40; v++) begin
      o = 1'($urandom_range(0, 1));
`ifdef VEXP_LANE_MASK_EN
      m = 4'($urandom_range(0, 15));
`else
      m = 4'hF;
`endif
      for (int l = 0; l < LANES; l++) begin
        x[16*l +: 16]   = rand_bf16();
        exp[16*l +: 16] = m[l] ? model(o, x[16*l +: 16]) : x[16*l +: 16];
      end
      run_vec("random", o, x, m, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
